// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM port arbiter.
// Grant state and master identifiers used by the top and the tag FIFO.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of master ids for reads accepted by the SDRAM port.
// Simultaneous push and pop are both honoured, even when full.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  master_id_t    din,
  output master_id_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  master_id_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port between
// an instruction-fetch master (m0) and a data master (m1).
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W          = 29,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic                s_readdatavalid,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                rsp_orphan
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t       state;
  master_id_t       last_grant;
  master_id_t       tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic             rd_room;
  logic             elig0;
  logic             elig1;
  logic             accept;
  logic             rsp_hit;

  always_comb begin
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    unique case (state)
      GRANT0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_byteenable = '1;
      end
      GRANT1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  assign accept = (state != IDLE) && (s_read || s_write)
               && !s_waitrequest;

  assign m0_waitrequest = !(state == GRANT0 && !s_waitrequest);
  assign m1_waitrequest = !(state == GRANT1 && !s_waitrequest);

  // Reads are held off while every tag slot is in use; writes never are.
  assign rd_room = !tag_full;
  assign elig0   = m0_read && rd_room;
  assign elig1   = m1_write || (m1_read && rd_room);

  assign rsp_hit          = s_readdatavalid && !tag_empty;
  assign m0_readdatavalid = rsp_hit && (tag_head == M0);
  assign m1_readdatavalid = rsp_hit && (tag_head == M1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      last_grant <= M1;
      rsp_orphan <= 1'b0;
    end else begin
      if (s_readdatavalid && tag_count == '0) begin
        rsp_orphan <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (elig0 && (!elig1 || last_grant == M1)) begin
            state      <= GRANT0;
            last_grant <= M0;
          end else if (elig1) begin
            state      <= GRANT1;
            last_grant <= M1;
          end
        end
        GRANT0: begin
          if (accept || !m0_read) begin
            state <= IDLE;
          end
        end
        GRANT1: begin
          if (accept || !(m1_read || m1_write)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (accept && s_read),
    .pop   (s_readdatavalid),
    .din   ((state == GRANT1) ? M1 : M0),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 29, Avalon word address width toward HPS SDRAM port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width DATA_W/8.
REQ-003 Parameter MAX_OUTSTANDING, default 4, max accepted-but-unreturned reads, power of two.
REQ-004 clk_clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_reset  in  1  synchronous, active-high reset.
REQ-006 m0_address  in  ADDR_W  instruction-fetch read address.
REQ-007 m0_read  in  1  instruction-fetch read request.
REQ-008 m0_waitrequest  out  1  m0 command not accepted this cycle.
REQ-009 m0_readdata  out  DATA_W  m0 read data.
REQ-010 m0_readdatavalid  out  1  m0_readdata valid.
REQ-011 m1_address  in  ADDR_W  data-port address.
REQ-012 m1_read / m1_write  in  1 each  data-port read / write request; never both high.
REQ-013 m1_writedata  in  DATA_W; m1_byteenable  in  DATA_W/8.
REQ-014 m1_waitrequest, m1_readdata (DATA_W), m1_readdatavalid  out  as m0.
REQ-015 s_address (ADDR_W), s_read, s_write, s_writedata (DATA_W), s_byteenable (DATA_W/8)  out  Avalon-MM master command to SDRAM port.
REQ-016 s_waitrequest, s_readdatavalid (1), s_readdata (DATA_W)  in  SDRAM port response.
REQ-017 rsp_orphan  out  1  sticky: readdatavalid arrived with no pending tag.

Function
REQ-018 State machine SHALL have states IDLE, GRANT0, GRANT1; grant is registered.
REQ-019 In IDLE, eligible requester: m0 if m0_read; m1 if m1_read or m1_write; a read is ineligible while pending-tag count == MAX_OUTSTANDING.
REQ-020 One eligible requester -> next state GRANTx; both eligible -> grant the one not granted last (round robin); none -> stay IDLE.
REQ-021 Last-grant pointer SHALL reset to 1, so m0 wins first contention.
REQ-022 In GRANTx, s_* command outputs SHALL combinationally mirror master x; m0 drives s_write=0, s_byteenable all-ones, s_writedata 0.
REQ-023 In IDLE, s_read=0, s_write=0; s_address/s_writedata/s_byteenable 0.
REQ-024 mx_waitrequest = NOT(state==GRANTx AND s_waitrequest==0); high in IDLE and when not granted.
REQ-025 Accept = GRANTx AND (s_read OR s_write) AND NOT s_waitrequest; on accept next state IDLE (max one command per 2 cycles).
REQ-026 Grant SHALL be held while s_waitrequest is high; no preemption.
REQ-027 On accepted read, master id SHALL be pushed into tag FIFO (depth MAX_OUTSTANDING, in order).
REQ-028 On s_readdatavalid with FIFO non-empty: pop head, assert mx_readdatavalid for head id same cycle, mx_readdata = s_readdata; other master's valid low.
REQ-029 Push and pop in same cycle SHALL both occur; count unchanged.
REQ-030 s_readdatavalid with FIFO empty: no master valid asserted, rsp_orphan set until reset.
REQ-031 m0_readdata/m1_readdata SHALL both carry s_readdata unconditionally; only valid strobes are steered.
REQ-032 Writes SHALL not push tags and are never blocked by FIFO full.

Reset
REQ-033 reset_reset high at a clock edge: state IDLE, last-grant 1, FIFO empty, rsp_orphan 0; all s_read/s_write and readdatavalid outputs 0, waitrequests 1, from next cycle.
REQ-034 Reset mid-transaction SHALL abandon the held command and drop pending tags; responses arriving after reset set rsp_orphan.

Structure
REQ-035 Package sdram_arb_pkg SHALL hold the state enum (IDLE, GRANT0, GRANT1) and master-id type (1 bit).
REQ-036 Tag FIFO SHALL be sub-module sdram_arb_tag_fifo (push, pop, din, dout, full, empty, count).

Verification
REQ-037 m0_read addr 0x100, s_waitrequest 0 -> s_read high with s_address 0x100 in cycle 2, m0_waitrequest low that cycle; s_readdatavalid with 0xDEADBEEF 3 cycles later -> m0_readdatavalid, m0_readdata 0xDEADBEEF.
REQ-038 m0_read and m1_write held continuously from reset -> grants alternate m0, m1, m0, m1; m1 write carries writedata 0x12345678, byteenable 0xF.
REQ-039 m1 issues 4 reads, no responses -> 5th m1_read stalled (waitrequest high), concurrent m1_write accepted; one s_readdatavalid -> 5th read accepted.
REQ-040 Interleaved reads m0,m1,m0 then 3 responses A,B,C -> m0 gets A, m1 gets B, m0 gets C; response coinciding with new read accept keeps count correct.
REQ-041 s_waitrequest high 5 cycles during GRANT1 -> s_* stable, no switch to m0; reset asserted mid-stall -> s_read 0 next cycle, later readdatavalid sets rsp_orphan.
